// File: rtl/vme_arb_pkg.sv
// vme_arb_pkg: shared types and constants for the VME command arbiter.
// Holds the arbiter state enum, the read-flag bit position and the idle command word.
package vme_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        RESP
    } arb_state_e;

    localparam int          VME_READ_BIT = 25;
    localparam logic [31:0] VME_IDLE_CMD = 32'h00F80000;

    // A command is a read when its read bit is set.
    function automatic logic is_read(input logic [31:0] cmd);
        return cmd[VME_READ_BIT];
    endfunction

endpackage

// File: rtl/vme_rr_pick.sv
// vme_rr_pick: combinational requester picker (round-robin, or fixed priority
// when VME_ARB_FIXED_PRIO_EN is defined).
// Ports: req_i request bits, ptr_i last-granted index,
//        gnt_o one-hot grant, idx_o grant index, any_o some request present.
module vme_rr_pick
    import vme_arb_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

`ifdef VME_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    // Descending scan: the lowest asserted index is written last and wins.
    always_comb begin
        idx_o = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end
`else
    // Scan offsets from farthest to nearest after the pointer, so the
    // first asserted index following ptr_i (with wrap) is written last.
    // Offset NREQ is the pointer itself: lowest priority.
    always_comb begin
        int j;
        j     = 0;
        idx_o = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j = int'(ptr_i) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (req_i[j]) begin
                idx_o = IW'(j);
            end
        end
    end
`endif

    always_comb begin
        any_o = |req_i;
        gnt_o = '0;
        if (any_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/vme_cmd_arbiter.sv
// vme_cmd_arbiter: shares one VME command path among NREQ requesters, one
// transaction at a time; round-robin by default, fixed priority with VME_ARB_FIXED_PRIO_EN.
// Ports: req_valid/req_cmd/req_dat/req_ack requester side; rsp_valid/rsp_dat/rsp_err
//        response; busy; start/vme_cmd_reg/vme_dat_reg_in/vme_cmd_rd/vme_dat_wr/
//        vme_dat_reg_out VME engine side.
module vme_cmd_arbiter
    import vme_arb_pkg::*;
#(
    parameter int          NREQ     = 2,
    parameter int          TIMEOUT  = 1023,
    parameter logic [31:0] IDLE_CMD = VME_IDLE_CMD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ*32-1:0] req_cmd,
    input  logic [NREQ*32-1:0] req_dat,
    output logic [NREQ-1:0]  req_ack,
    output logic [NREQ-1:0]  rsp_valid,
    output logic [31:0]      rsp_dat,
    output logic             rsp_err,
    output logic             busy,
    output logic             start,
    output logic [31:0]      vme_cmd_reg,
    output logic [31:0]      vme_dat_reg_in,
    input  logic             vme_cmd_rd,
    input  logic             vme_dat_wr,
    input  logic [31:0]      vme_dat_reg_out
);

    localparam int IW  = $clog2(NREQ);
    localparam int CWR = $clog2(TIMEOUT + 1);
    localparam int CW  = (CWR > 10) ? CWR : 10;

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            start_q, start_d;
    logic [31:0]     vcmd_q, vcmd_d;
    logic [31:0]     vdat_q, vdat_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] rv_q, rv_d;
    logic [31:0]     rdat_q, rdat_d;
    logic            rerr_q, rerr_d;

    logic [IW-1:0]   ptr;
    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [31:0]     pick_cmd;
    logic [31:0]     pick_dat;
    logic            tmo;
    logic            abort;

`ifndef VME_ARB_FIXED_PRIO_EN
    logic [IW-1:0]   ptr_q, ptr_d;
    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    vme_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign pick_cmd = req_cmd[int'(pick_idx) * 32 +: 32];
    assign pick_dat = req_dat[int'(pick_idx) * 32 +: 32];

    // Counter runs from 0 after the grant edge; the edge on which it
    // would reach TIMEOUT is the abort edge.
    assign tmo = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        start_d = start_q;
        vcmd_d  = vcmd_q;
        vdat_d  = vdat_q;
        ack_d   = '0;
        rv_d    = '0;
        rdat_d  = rdat_q;
        rerr_d  = rerr_q;
        abort   = 1'b0;
`ifndef VME_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    ack_d   = pick_gnt;
                    gnt_d   = pick_gnt;
                    rd_d    = is_read(pick_cmd);
                    vcmd_d  = pick_cmd;
                    vdat_d  = pick_dat;
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ISSUE;
`ifndef VME_ARB_FIXED_PRIO_EN
                    ptr_d   = pick_idx;
`endif
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + CW'(1);
                if (tmo) begin
                    abort = 1'b1;
                end else if (vme_cmd_rd) begin
                    start_d = 1'b0;
                    vcmd_d  = IDLE_CMD;
                    vdat_d  = '0;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                cnt_d = cnt_q + CW'(1);
                // A completion on the abort edge still counts as success.
                if (vme_dat_wr) begin
                    rdat_d  = rd_q ? vme_dat_reg_out : 32'h0;
                    rerr_d  = 1'b0;
                    rv_d    = gnt_q;
                    state_d = RESP;
                end else if (tmo) begin
                    abort = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            start_d = 1'b0;
            vcmd_d  = IDLE_CMD;
            vdat_d  = '0;
            rdat_d  = '0;
            rerr_d  = 1'b1;
            rv_d    = gnt_q;
            state_d = RESP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rd_q    <= 1'b0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            vcmd_q  <= IDLE_CMD;
            vdat_q  <= '0;
            ack_q   <= '0;
            rv_q    <= '0;
            rdat_q  <= '0;
            rerr_q  <= 1'b0;
`ifndef VME_ARB_FIXED_PRIO_EN
            ptr_q   <= IW'(NREQ - 1);
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            vcmd_q  <= vcmd_d;
            vdat_q  <= vdat_d;
            ack_q   <= ack_d;
            rv_q    <= rv_d;
            rdat_q  <= rdat_d;
            rerr_q  <= rerr_d;
`ifndef VME_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign req_ack        = ack_q;
    assign rsp_valid      = rv_q;
    assign rsp_dat        = rdat_q;
    assign rsp_err        = rerr_q;
    assign busy           = (state_q != IDLE);
    assign start          = start_q;
    assign vme_cmd_reg    = vcmd_q;
    assign vme_dat_reg_in = vdat_q;

endmodule

// File: tb/tb_vme_cmd_arbiter.sv
// tb_vme_cmd_arbiter: directed bench for vme_cmd_arbiter (NREQ=2, TIMEOUT=16).
// Expected grant order follows VME_ARB_FIXED_PRIO_EN when it is defined.
module tb_vme_cmd_arbiter;

    localparam int          NREQ = 2;
    localparam int          TMO  = 16;
    localparam logic [31:0] IDLE_W = 32'h00F80000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*32-1:0] req_cmd;
    logic [NREQ*32-1:0] req_dat;
    logic [NREQ-1:0]   req_ack;
    logic [NREQ-1:0]   rsp_valid;
    logic [31:0]       rsp_dat;
    logic              rsp_err;
    logic              busy;
    logic              start;
    logic [31:0]       vme_cmd_reg;
    logic [31:0]       vme_dat_reg_in;
    logic              vme_cmd_rd;
    logic              vme_dat_wr;
    logic [31:0]       vme_dat_reg_out;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    vme_cmd_arbiter #(
        .NREQ     (NREQ),
        .TIMEOUT  (TMO),
        .IDLE_CMD (IDLE_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_cmd         (req_cmd),
        .req_dat         (req_dat),
        .req_ack         (req_ack),
        .rsp_valid       (rsp_valid),
        .rsp_dat         (rsp_dat),
        .rsp_err         (rsp_err),
        .busy            (busy),
        .start           (start),
        .vme_cmd_reg     (vme_cmd_reg),
        .vme_dat_reg_in  (vme_dat_reg_in),
        .vme_cmd_rd      (vme_cmd_rd),
        .vme_dat_wr      (vme_dat_wr),
        .vme_dat_reg_out (vme_dat_reg_out)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_start"}, 32'(start), 32'd0);
        check({tag, "_cmd"}, vme_cmd_reg, IDLE_W);
        check({tag, "_datin"}, vme_dat_reg_in, 32'd0);
        check({tag, "_ack"}, 32'(req_ack), 32'd0);
        check({tag, "_rspv"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rdat"}, rsp_dat, 32'd0);
        check({tag, "_rerr"}, 32'(rsp_err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_ack(output logic [NREQ-1:0] a);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ack == '0 && n < 20);
        check("ack_seen", 32'(req_ack != '0), 32'd1);
        a = req_ack;
    endtask

    task automatic wait_rsp(output logic [NREQ-1:0] r);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_valid == '0 && n < 40);
        check("rsp_seen", 32'(rsp_valid != '0), 32'd1);
        r = rsp_valid;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] a;
        logic [NREQ-1:0] r;
        logic [NREQ-1:0] ord [4];
        int              n;

`ifdef VME_ARB_FIXED_PRIO_EN
        ord = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        ord = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        rst_n           = 1'b0;
        req_valid       = '0;
        req_cmd         = '0;
        req_dat         = '0;
        vme_cmd_rd      = 1'b0;
        vme_dat_wr      = 1'b0;
        vme_dat_reg_out = '0;
        step(2);
        check_reset("rst");
        rst_n = 1'b1;
        step(1);

        // Single write from requester 0; engine ready after 3 cycles.
        req_cmd[31:0] = 32'h01000020;
        req_dat[31:0] = 32'h0000ABCD;
        req_valid     = 2'b01;
        step(1);
        check("wr_ack", 32'(req_ack), 32'd1);
        check("wr_start", 32'(start), 32'd1);
        check("wr_cmd", vme_cmd_reg, 32'h01000020);
        check("wr_datin", vme_dat_reg_in, 32'h0000ABCD);
        check("wr_busy", 32'(busy), 32'd1);
        req_valid = '0;
        step(1);
        check("wr_start_h1", 32'(start), 32'd1);
        check("wr_ack_pulse", 32'(req_ack), 32'd0);
        step(1);
        check("wr_start_h2", 32'(start), 32'd1);
        vme_cmd_rd = 1'b1;
        step(1);
        check("wr_start_off", 32'(start), 32'd0);
        check("wr_cmd_idle", vme_cmd_reg, IDLE_W);
        check("wr_datin_0", vme_dat_reg_in, 32'd0);
        vme_cmd_rd = 1'b0;
        step(4);
        check("wr_no_rsp", 32'(rsp_valid), 32'd0);
        vme_dat_wr      = 1'b1;
        vme_dat_reg_out = 32'hCAFEF00D;
        step(1);
        check("wr_rspv", 32'(rsp_valid), 32'd1);
        check("wr_rdat", rsp_dat, 32'd0);
        check("wr_rerr", 32'(rsp_err), 32'd0);
        vme_dat_wr = 1'b0;
        step(1);
        check("wr_rspv_pulse", 32'(rsp_valid), 32'd0);
        check("wr_idle", 32'(busy), 32'd0);

        // Read from requester 1.
        req_cmd[63:32] = 32'h02000040;
        req_valid      = 2'b10;
        step(1);
        check("rd_ack", 32'(req_ack), 32'd2);
        req_valid  = '0;
        vme_cmd_rd = 1'b1;
        step(1);
        check("rd_start_off", 32'(start), 32'd0);
        vme_cmd_rd      = 1'b0;
        vme_dat_wr      = 1'b1;
        vme_dat_reg_out = 32'h12345678;
        step(1);
        check("rd_rspv", 32'(rsp_valid), 32'd2);
        check("rd_rdat", rsp_dat, 32'h12345678);
        check("rd_rerr", 32'(rsp_err), 32'd0);
        vme_dat_wr      = 1'b0;
        vme_dat_reg_out = '0;
        step(1);

        // Contention: both requesters held valid for four transactions.
        req_cmd[31:0]   = 32'h01000020;
        req_cmd[63:32]  = 32'h01000024;
        vme_cmd_rd      = 1'b1;
        vme_dat_wr      = 1'b1;
        vme_dat_reg_out = 32'hDEADBEEF;
        req_valid       = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_ack(a);
            check("cont_ack", 32'(a), 32'(ord[t]));
            if (t == 3) begin
                req_valid = '0;
            end
            wait_rsp(r);
            check("cont_rsp", 32'(r), 32'(ord[t]));
            check("cont_rdat", rsp_dat, 32'd0);
        end
        vme_cmd_rd      = 1'b0;
        vme_dat_wr      = 1'b0;
        vme_dat_reg_out = '0;
        step(2);
        check("cont_idle", 32'(busy), 32'd0);

        // Timeout: engine never ready.
        req_valid = 2'b01;
        wait_ack(a);
        check("tmo_ack", 32'(a), 32'd1);
        req_valid = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == TMO - 1) begin
                check("tmo_start_hold", 32'(start), 32'd1);
            end
        end while (rsp_valid == '0 && n < 40);
        check("tmo_cycles", 32'(n), 32'(TMO));
        check("tmo_rspv", 32'(rsp_valid), 32'd1);
        check("tmo_rerr", 32'(rsp_err), 32'd1);
        check("tmo_rdat", rsp_dat, 32'd0);
        check("tmo_start", 32'(start), 32'd0);
        check("tmo_cmd", vme_cmd_reg, IDLE_W);
        step(1);

        // Reset in WAIT_DONE.
        req_valid = 2'b10;
        wait_ack(a);
        check("mr_ack", 32'(a), 32'd2);
        req_valid  = '0;
        vme_cmd_rd = 1'b1;
        step(1);
        vme_cmd_rd = 1'b0;
        check("mr_busy", 32'(busy), 32'd1);
        check("mr_wait", 32'(start), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("mr");
        vme_dat_wr = 1'b1;
        step(1);
        vme_dat_wr = 1'b0;
        rst_n      = 1'b1;
        req_valid  = 2'b11;
        wait_ack(a);
        check("mr_first_gnt", 32'(a), 32'd1);
        req_valid  = '0;
        vme_cmd_rd = 1'b1;
        step(1);
        vme_cmd_rd = 1'b0;
        vme_dat_wr = 1'b1;
        step(1);
        check("mr_rspv", 32'(rsp_valid), 32'd1);
        vme_dat_wr = 1'b0;
        step(1);

        // Stray completion in IDLE, then in ISSUE; requester 1 withdraws.
        vme_dat_wr = 1'b1;
        step(1);
        check("st_idle_rspv", 32'(rsp_valid), 32'd0);
        check("st_idle_busy", 32'(busy), 32'd0);
        vme_dat_wr = 1'b0;
        step(1);
        check("st_idle_ack", 32'(req_ack), 32'd0);
        req_valid = 2'b01;
        wait_ack(a);
        check("st_ack", 32'(a), 32'd1);
        req_valid  = 2'b10;
        vme_dat_wr = 1'b1;
        step(1);
        check("st_iss_rspv", 32'(rsp_valid), 32'd0);
        check("st_iss_start", 32'(start), 32'd1);
        check("st_iss_busy", 32'(busy), 32'd1);
        req_valid  = '0;
        vme_dat_wr = 1'b0;
        vme_cmd_rd = 1'b1;
        step(1);
        check("st_wait", 32'(start), 32'd0);
        vme_cmd_rd = 1'b0;
        vme_dat_wr = 1'b1;
        step(1);
        check("st_rspv", 32'(rsp_valid), 32'd1);
        vme_dat_wr = 1'b0;
        step(1);
        check("wd_ack1", 32'(req_ack), 32'd0);
        step(1);
        check("wd_ack2", 32'(req_ack), 32'd0);
        check("wd_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/vme_cmd_arbiter.md
Name: vme_cmd_arbiter

Overview:
- Shares the single VME command path (start / vme_cmd_reg / vme_dat_reg_in, with the vme_cmd_rd and vme_dat_wr handshake) between NREQ command requesters.
- Typical requesters: the file-driven command player and the on-board slow-control sequencer.
- Grants one transaction at a time with round-robin fairness, sequences issue and completion, and returns read data or a timeout status to the granted requester.

Parameters:
- NREQ, 2, number of requesters (2..8).
- TIMEOUT, 1023, max cycles from grant to completion before abort (10-bit counter minimum).
- IDLE_CMD, 32'h00F80000, value driven on vme_cmd_reg when no command is presented.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  requester i has a command pending; held until req_ack[i].
- req_cmd  in  NREQ*32  command word of requester i, slice [32*i+31:32*i].
- req_dat  in  NREQ*32  write data of requester i.
- req_ack  out  NREQ  one-cycle pulse: command of requester i latched.
- rsp_valid  out  NREQ  one-cycle pulse: transaction of requester i finished.
- rsp_dat  out  32  read data, valid with rsp_valid.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- busy  out  1  high in any state except IDLE.
- start  out  1  command strobe to VME engine.
- vme_cmd_reg  out  32  command word to VME engine.
- vme_dat_reg_in  out  32  write data to VME engine.
- vme_cmd_rd  in  1  VME engine ready to accept a command.
- vme_dat_wr  in  1  VME engine completion strobe.
- vme_dat_reg_out  in  32  read data from VME engine.

Behaviour:
- Reset values:
  - start=0, vme_cmd_reg=IDLE_CMD, vme_dat_reg_in=0.
  - req_ack=0, rsp_valid=0, rsp_dat=0, rsp_err=0, busy=0.
  - State=IDLE, last-grant pointer=NREQ-1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, WAIT_DONE, RESP.
- IDLE:
  - If any req_valid, select the first asserted index searching from pointer+1 with wrap.
  - Latch cmd, dat, and read flag = req_cmd[25].
  - Pulse req_ack[g] and update pointer=g. Go to ISSUE next cycle.
  - Grant decision latency: 1 cycle from req_valid.
- ISSUE:
  - Drive start=1, vme_cmd_reg=latched cmd, vme_dat_reg_in=latched dat.
  - Transfer occurs on the edge where start=1 and vme_cmd_rd=1. Next cycle: start=0, vme_cmd_reg=IDLE_CMD, vme_dat_reg_in=0, state WAIT_DONE.
  - start is never high for more than one accepted edge.
- WAIT_DONE:
  - On vme_dat_wr=1: capture rsp_dat = vme_dat_reg_out if read flag set, else 0; rsp_err=0; go to RESP.
  - vme_dat_wr seen while in ISSUE or IDLE is ignored.
- RESP: rsp_valid[g]=1 for exactly one cycle, then IDLE. No new grant is issued in the RESP cycle.
- Timeout:
  - Counter clears at grant and increments in ISSUE and WAIT_DONE.
  - Reaching TIMEOUT forces command outputs to idle values, rsp_dat=0, rsp_err=1, state RESP.
- Boundary conditions:
  - Requester deasserting req_valid before grant: legal; no ack, no transaction.
  - All requesters valid: grants rotate 0,1,...,NREQ-1,0; no requester waits more than NREQ-1 transactions.
  - Reset mid-transaction: immediate return to reset values; no rsp_valid for the aborted transaction.
  - Single requester: back-to-back grants allowed; minimum spacing is the IDLE→ISSUE→WAIT_DONE→RESP loop.

Optional Feature:
- Macro: VME_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins every arbitration; pointer logic removed.
- Undefined (default): round-robin as above.
- All other timing is identical in both builds.

Decomposition:
- Package vme_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT_DONE, RESP);
  - VME_READ_BIT=25;
  - VME_IDLE_CMD=32'h00F80000.
- One sub-module, vme_rr_pick: combinational round-robin/fixed-priority picker taking NREQ request bits and the pointer, returning a one-hot grant and an index. The top level holds the FSM, latches and timeout counter.

Test Plan:
- Single write: req_valid[0], cmd=32'h01000020, dat=32'h0000ABCD; VME ready after 3 cycles, vme_dat_wr 5 cycles later.
  - Expect: req_ack[0] 1 cycle after valid; start high until the ready edge, then low; rsp_valid[0] with rsp_dat=0, rsp_err=0.
- Read: cmd bit25=1, vme_dat_reg_out=32'h12345678 at vme_dat_wr.
  - Expect: rsp_dat=32'h12345678, rsp_valid[1] for the granted requester 1.
- Contention: both requesters held valid for 4 transactions.
  - Expect: grant order 0,1,0,1. With VME_ARB_FIXED_PRIO_EN defined, expect 0,0,0,0.
- Timeout: TIMEOUT=16, vme_cmd_rd held 0.
  - Expect: rsp_valid with rsp_err=1 exactly 16 cycles after grant; start=0 and vme_cmd_reg=32'h00F80000 afterwards.
- Reset mid-op: rst_n low during WAIT_DONE.
  - Expect: all outputs at reset values asynchronously; no rsp_valid; next grant goes to requester 0.
- Stray completion: vme_dat_wr pulsed in IDLE and in ISSUE.
  - Expect: no rsp_valid, no state change.
